// File: rtl/audio_ram_sequencer_if.sv
// rtl/audio_ram_sequencer_if.sv - shared RAM port, playback stream and debug read port bundle
interface audio_ram_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] play_data;
  logic              play_valid;
  logic              play_ready;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  modport master (
    output ram_addr, ram_din, ram_we,
    input  ram_dout,
    output play_data, play_valid,
    input  play_ready,
    input  dbg_req, dbg_addr,
    output dbg_gnt, dbg_rdata, dbg_rvalid
  );

  modport slave (
    input  ram_addr, ram_din, ram_we,
    output ram_dout,
    input  play_data, play_valid,
    output play_ready,
    output dbg_req, dbg_addr,
    input  dbg_gnt, dbg_rdata, dbg_rvalid
  );
endinterface

// File: rtl/audio_ram_sequencer.sv
// rtl/audio_ram_sequencer.sv - record/playback session controller and single-port RAM arbiter
module audio_ram_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int PLAY_DIV = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_record,
  input  logic                  btn_play,
  output logic                  rec_en,
  input  logic [ADDR_W-1:0]     rec_addr,
  input  logic [DATA_W-1:0]     rec_dout,
  input  logic                  rec_we,
  audio_ram_sequencer_if.master bus,
  output logic                  busy,
  output logic [1:0]            state
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REC = 2'd1, S_PLAY = 2'd2} state_t;

  localparam int CNT_W = (PLAY_DIV > 1) ? $clog2(PLAY_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PLAY_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic              rec_btn_q, play_btn_q, rec_en_q;
  logic [ADDR_W:0]   rec_len_q;
  logic              first_seen_q;
  logic [ADDR_W-1:0] start_addr_q, idx_q;
  logic [CNT_W-1:0]  tick_cnt_q;
  logic              pend_q, play_rd_q, dbg_rd_q, play_valid_q;
  logic [DATA_W-1:0] play_data_q;

  logic rec_rise, play_rise, rec_wr, tick, play_rd, dbg_gnt, hs, last_hs;

  assign rec_rise  = btn_record & ~rec_btn_q;
  assign play_rise = btn_play & ~play_btn_q;
  // rst_n gating kills a write presented in the same cycle reset is asserted
  assign rec_wr    = rst_n & (state_q == S_REC) & rec_we;
  assign tick      = (state_q == S_PLAY) && (tick_cnt_q == '0);
  assign play_rd   = rst_n & (state_q == S_PLAY) & (pend_q | tick) & ~play_valid_q
                     & ~play_rd_q & ~play_rise;
  assign dbg_gnt   = rst_n & bus.dbg_req & ~rec_wr & ~play_rd;
  assign hs        = (state_q == S_PLAY) & play_valid_q & bus.play_ready;
  assign last_hs   = hs && ({1'b0, idx_q} == (rec_len_q - LEN_ONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rec_rise) state_d = S_REC;
        else if (play_rise && rec_len_q != '0) state_d = S_PLAY;
      end
      S_REC:   if (rec_rise || (rec_wr && rec_len_q == (LEN_FULL - LEN_ONE))) state_d = S_IDLE;
      S_PLAY:  if (play_rise || last_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rec_btn_q    <= 1'b0;
      play_btn_q   <= 1'b0;
      rec_en_q     <= 1'b0;
      rec_len_q    <= '0;
      first_seen_q <= 1'b0;
      start_addr_q <= '0;
      idx_q        <= '0;
      tick_cnt_q   <= '0;
      pend_q       <= 1'b0;
      play_rd_q    <= 1'b0;
      dbg_rd_q     <= 1'b0;
      play_valid_q <= 1'b0;
      play_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rec_btn_q  <= btn_record;
      play_btn_q <= btn_play;
      rec_en_q   <= (state_q == S_REC);
      play_rd_q  <= play_rd;
      dbg_rd_q   <= dbg_gnt;

      if (state_q == S_IDLE && rec_rise) begin
        rec_len_q    <= '0;
        first_seen_q <= 1'b0;
      end
      if (rec_wr) begin
        rec_len_q <= rec_len_q + LEN_ONE;
        if (!first_seen_q) begin
          start_addr_q <= rec_addr;
          first_seen_q <= 1'b1;
        end
      end

      // At most one tick is remembered while the consumer stalls
      if (state_q == S_PLAY) begin
        tick_cnt_q <= (tick_cnt_q == CNT_MAX) ? '0 : tick_cnt_q + CNT_ONE;
        pend_q     <= (pend_q | tick) & ~play_rd;
        if (hs) idx_q <= idx_q + ADDR_ONE;
      end else begin
        tick_cnt_q <= '0;
        pend_q     <= 1'b0;
        idx_q      <= '0;
      end

      if (state_q != S_PLAY || play_rise || hs) begin
        play_valid_q <= 1'b0;
      end else if (play_rd_q) begin
        play_valid_q <= 1'b1;
        play_data_q  <= bus.ram_dout;
      end
    end
  end

  assign bus.ram_we     = rec_wr;
  assign bus.ram_din    = rec_wr ? rec_dout : '0;
  assign bus.ram_addr   = rec_wr  ? rec_addr :
                          play_rd ? (start_addr_q + idx_q) :
                          dbg_gnt ? bus.dbg_addr : '0;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rvalid = dbg_rd_q;
  assign bus.dbg_rdata  = dbg_rd_q ? bus.ram_dout : '0;
  assign bus.play_valid = play_valid_q;
  assign bus.play_data  = play_data_q;

  assign rec_en = rec_en_q;
  assign busy   = (state_q != S_IDLE);
  assign state  = state_q;
endmodule

// File: doc/audio_ram_sequencer.md
Name: audio_ram_sequencer

Overview:
- Session controller for the shared 16x65536 sample RAM behind the PDM sound recorder.
- Sequences record and playback sessions from two push-buttons and enables the recorder during record.
- Streams recorded samples back out at a fixed sample rate over a valid/ready port.
- Arbitrates the single RAM port between recorder writes, playback reads and a low-priority debug/dump read port.

Parameters:
ADDR_W, 16, RAM address width; capacity is 2^ADDR_W words
DATA_W, 16, sample/RAM data width
PLAY_DIV, 512, clk cycles per playback sample tick (range 2..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
btn_record  in  1  record button level; rising edge detected internally
btn_play  in  1  play button level; rising edge detected internally
rec_en  out  1  enables the recorder; high only in REC
rec_addr  in  ADDR_W  recorder write address
rec_dout  in  DATA_W  recorder write data
rec_we  in  1  recorder write strobe, single-cycle
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_dout  in  DATA_W  RAM read data, valid 1 cycle after its address
play_data  out  DATA_W  playback sample
play_valid  out  1  playback sample valid
play_ready  in  1  playback consumer ready
dbg_req  in  1  debug read request, held until granted
dbg_addr  in  ADDR_W  debug read address
dbg_gnt  out  1  debug request accepted this cycle
dbg_rdata  out  DATA_W  debug read data
dbg_rvalid  out  1  dbg_rdata valid, 1-cycle pulse
busy  out  1  state != IDLE
state  out  2  0=IDLE, 1=REC, 2=PLAY

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs 0; state IDLE.
  - rec_len=0, start_addr=0, edge-detect registers cleared.
  - Reset mid-session aborts immediately; the RAM write in flight that cycle is suppressed.
- Edge detect: rise = btn & ~btn_q. Only rising edges act; held levels do nothing.
- IDLE:
  - record rise -> REC: rec_len=0, first_seen=0.
  - play rise with rec_len!=0 -> PLAY. play rise with rec_len==0 is ignored.
  - Simultaneous rises: record wins.
- REC:
  - rec_en=1 (registered; asserted the cycle after entry).
  - Each rec_we drives ram_we=1, ram_addr=rec_addr, ram_din=rec_dout combinationally-registered in the same cycle as rec_we reaches the block, and increments rec_len (ADDR_W+1 bits).
  - The first write latches start_addr=rec_addr.
  - Exits to IDLE when rec_len reaches 2^ADDR_W or on a record rise (abort; rec_len keeps the count so far); rec_en=0 from the next cycle.
  - Play rises are ignored.
- rec_we outside REC is dropped: ram_we=0.
- PLAY:
  - Tick counter 0..PLAY_DIV-1; it starts at 0 on entry, and a tick fires on entry.
  - Tick sets pend.
  - When pend=1, play_valid=0 and the port is free, issue a read at start_addr+idx (mod 2^ADDR_W) and clear pend.
  - The next cycle loads play_data and sets play_valid=1.
  - Handshake: play_valid&play_ready -> play_valid=0, idx++.
  - A tick during a stall is held in pend (at most one pending; extra ticks are lost, never queued).
  - After the handshake with idx==rec_len-1 -> IDLE; no further reads.
  - Play rise aborts: play_valid=0 next cycle, -> IDLE. Record rises are ignored.
- Port priority per cycle: REC write > playback read > debug read.
  - dbg_gnt=1 only when dbg_req=1 and no higher-priority access that cycle.
  - On grant: ram_addr=dbg_addr, and dbg_rvalid pulses the next cycle with dbg_rdata=ram_dout.
  - In REC, debug is granted in cycles without rec_we.
- Read return routing uses a 1-bit tag registered with each read: playback vs debug.

Test Plan:
- Reset, then record rise; 4 rec_we at addresses 1..4 with data 0xA1..0xA4 -> rec_en=1, four ram_we pulses with matching addr/data, rec_len=4; record rise -> IDLE, rec_en=0 one cycle later.
- After the above, play rise with PLAY_DIV=8 and play_ready=1 -> play_data 0xA1, 0xA2, 0xA3, 0xA4 with play_valid rising 8 cycles apart; state returns to 0 after the 4th handshake.
- Playback with play_ready held 0 for 30 cycles -> play_valid stays 1 with 0xA1; exactly one further read is issued immediately after the handshake (pending tick), with no duplicate sample.
- dbg_req coincident with rec_we in REC -> dbg_gnt=0 that cycle and 1 the next; dbg_rvalid 1 cycle after grant with the RAM contents.
- Play rise with rec_len=0 -> state stays IDLE. Simultaneous record and play rises in IDLE -> REC.
- rst_n=0 mid-PLAY with play_valid=1 -> all outputs 0 on the next edge; rec_len=0, so a subsequent play rise is ignored.
